seg_scan_ctrl: RTL

Time-multiplexing scan controller that shares one `PL_L0_BCD7` 7-segment decoder among `NDIGITS` common-anode digits. It holds a double-buffered digit word and presents one nibble at a time to the decoder's `val`/`hex` inputs. It drives the matching active-low digit enable and inserts a dead-time blank between digits to prevent ghosting. It sits between the application logic (which loads values) and the board's segment/anode pins.

---
 rtl/seg_scan_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg_scan_ctrl                                                 |
// | Purpose  : Multiplexed common-anode 7-segment scan with dead-time blank. |
// |            Define SEG_SCAN_LZB_EN for leading-zero blanking.             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module seg_scan_ctrl #(
  parameter int NDIGITS = 4,
  parameter int CBITS   = 16,
  parameter int DEAD    = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load,
  input  logic [4*NDIGITS-1:0]   i_val,
  input  logic                   i_hex,
  output logic [3:0]             o_val,
  output logic                   o_hex,
  output logic [NDIGITS-1:0]     o_dig_en,
  output logic                   o_frame
);

  localparam int            IW          = $clog2(NDIGITS);
  localparam logic [0:0]    S_BLANK     = 1'b0;
  localparam logic [0:0]    S_SHOW      = 1'b1;
  localparam logic [3:0]    C_DEAD_LAST = 4'(DEAD - 1);
  localparam logic [IW-1:0] C_LAST_IDX  = IW'(NDIGITS - 1);

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [4*NDIGITS-1:0] r_pend;
  logic                 r_pend_hex;
  logic [4*NDIGITS-1:0] r_disp;
  logic                 r_disp_hex;
  logic [IW-1:0]        r_idx;
  logic [CBITS-1:0]     r_pre;
  logic [3:0]           r_dcnt;

  logic                 w_blank_end;
  logic                 w_slot_end;
  logic                 w_wrap;
  logic                 w_lz_blank;
  logic [NDIGITS-1:0]   w_dig_en_nxt;
  logic [3:0]           w_val_nxt;
  logic                 w_hex_nxt;

  assign w_blank_end = (r_state == S_BLANK) && (r_dcnt == C_DEAD_LAST);
  assign w_slot_end  = (r_state == S_SHOW) && (&r_pre);
  assign w_wrap      = w_slot_end && (r_idx == C_LAST_IDX);

`ifdef SEG_SCAN_LZB_EN
  // w_upper_zero[d]: every nibble from digit d upward is zero.
  logic [NDIGITS-1:0] w_upper_zero;
  generate
    for (genvar d = 0; d < NDIGITS; d++) begin : g_lz
      assign w_upper_zero[d] = (r_disp[4*NDIGITS-1:4*d] == '0);
    end
  endgenerate
  assign w_lz_blank = (r_idx != '0) && w_upper_zero[r_idx];
`else
  assign w_lz_blank = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_BLANK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BLANK: if (w_blank_end) w_state_nxt = S_SHOW;
      S_SHOW:  if (w_slot_end)  w_state_nxt = S_BLANK;
    endcase
  end

  // Outputs are decoded from the current state and registered, so the anode
  // lags the state by one cycle; o_frame is registered from the wrap edge.
  always_comb begin
    w_dig_en_nxt = '1;
    w_val_nxt    = o_val;
    w_hex_nxt    = o_hex;
    if (r_state == S_SHOW) begin
      w_val_nxt = r_disp[{r_idx, 2'b00} +: 4];
      w_hex_nxt = r_disp_hex;
      if (!w_lz_blank) w_dig_en_nxt[r_idx] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend     <= '0;
      r_pend_hex <= 1'b0;
      r_disp     <= '0;
      r_disp_hex <= 1'b0;
      r_idx      <= '0;
      r_pre      <= '0;
      r_dcnt     <= '0;
    end else begin
      if (i_load) begin
        r_pend     <= i_val;
        r_pend_hex <= i_hex;
      end
      if (r_state == S_BLANK) begin
        if (w_blank_end) begin
          r_dcnt <= '0;
          r_pre  <= '0;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
      end else if (w_slot_end) begin
        r_pre <= '0;
        if (w_wrap) begin
          r_idx      <= '0;
          r_disp     <= r_pend;
          r_disp_hex <= r_pend_hex;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dig_en <= '1;
      o_val    <= '0;
      o_hex    <= 1'b0;
      o_frame  <= 1'b0;
    end else begin
      o_dig_en <= w_dig_en_nxt;
      o_val    <= w_val_nxt;
      o_hex    <= w_hex_nxt;
      o_frame  <= w_wrap;
    end
  end

endmodule
`default_nettype wire
